// File: rtl/gray_sobel_frame_sequencer.sv
// Frame sequencer in front of the grayscale/Sobel core: latches mode and
// geometry, feeds one core start strobe per accepted pixel, qualifies core
// results into a valid-tagged stream and reports frame done / errors.
//
// state  | meaning
// IDLE   | waiting for frame_start_i, config latched on the pulse
// LOAD   | one cycle, geometry checked against the mode
// STREAM | accepting input pixels, one core strobe per accept
// DRAIN  | input closed, collecting remaining outputs under a watchdog
// DONE   | one cycle, frame complete pulse
module gray_sobel_frame_sequencer #(
    parameter int MAX_PIXEL_BITS  = 24,
    parameter int PIXEL_WIDTH_OUT = 8,
    parameter int DIM_BITS        = 10,
    parameter int GRAY_LAT        = 1,
    parameter int TIMEOUT         = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                cfg_select_i,
    input  logic [DIM_BITS-1:0]       cfg_width_i,
    input  logic [DIM_BITS-1:0]       cfg_height_i,
    input  logic                      frame_start_i,
    input  logic                      in_valid_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
    output logic                      in_ready_o,
    output logic [1:0]                core_select_o,
    output logic                      core_start_o,
    output logic [MAX_PIXEL_BITS-1:0] core_pixel_o,
    input  logic [MAX_PIXEL_BITS-1:0] core_pixel_i,
    input  logic                      core_px_ready_i,
    output logic                      out_valid_o,
    output logic [MAX_PIXEL_BITS-1:0] out_pixel_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int CW = 2 * DIM_BITS;
    localparam int TW = $clog2(TIMEOUT + 1);

    if (GRAY_LAT < 1 || GRAY_LAT > 7) begin : g_bad_lat
        $error("GRAY_LAT must be in 1..7");
    end
    if (PIXEL_WIDTH_OUT > MAX_PIXEL_BITS) begin : g_bad_width
        $error("PIXEL_WIDTH_OUT must not exceed MAX_PIXEL_BITS");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            sel_q;
    logic [DIM_BITS-1:0]   width_q, height_q;
    logic [CW-1:0]         in_cnt, out_cnt;
    logic [CW-1:0]         n_in, n_out;
    logic [GRAY_LAT-1:0]   gray_sr;
    logic [TW-1:0]         tmo_cnt;
    logic                  sobel_mode, cfg_ok;
    logic                  accept, last_in, qual, take, frame_full;

    // Geometry derived from the latched config; Sobel loses a one-pixel border.
    assign sobel_mode = (sel_q == 2'b01) || (sel_q == 2'b10);
    assign cfg_ok     = sobel_mode ? (width_q >= DIM_BITS'(3) && height_q >= DIM_BITS'(3))
                                   : (width_q != '0 && height_q != '0);
    assign n_in       = CW'(width_q) * CW'(height_q);
    assign n_out      = sobel_mode ? CW'(width_q - DIM_BITS'(2)) * CW'(height_q - DIM_BITS'(2))
                                   : n_in;
    assign accept     = (state == S_STREAM) && in_valid_i;
    assign last_in    = (in_cnt == n_in - CW'(1));
    assign frame_full = (out_cnt == n_out);
    assign take       = qual && (state == S_STREAM || state == S_DRAIN) && (out_cnt < n_out);

    // Select which core-side event marks a valid result for the active mode.
    always_comb begin
        qual = 1'b0;
        case (sel_q)
            2'b00:   qual = gray_sr[GRAY_LAT-1];
            2'b11:   qual = gray_sr[0];
            default: qual = core_px_ready_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_start_i) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = cfg_ok ? S_STREAM : S_IDLE;
            S_STREAM: if (accept && last_in) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (frame_full)          state_nxt = S_DONE;
                else if (tmo_cnt == '0)  state_nxt = S_IDLE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready_o    = (state == S_STREAM);
        busy_o        = (state != S_IDLE);
        done_o        = (state == S_DONE);
        core_select_o = (state == S_IDLE) ? 2'b00 : sel_q;
        err_o         = ((state == S_LOAD) && !cfg_ok) ||
                        ((state == S_DRAIN) && !frame_full && (tmo_cnt == '0));
    end

    // Config latch, core drive, result capture, counters and drain watchdog.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            core_start_o <= 1'b0;
            core_pixel_o <= '0;
            gray_sr      <= '0;
            out_valid_o  <= 1'b0;
            out_pixel_o  <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            tmo_cnt      <= TW'(TIMEOUT);
        end else begin
            if (state == S_IDLE && frame_start_i) begin
                sel_q    <= cfg_select_i;
                width_q  <= cfg_width_i;
                height_q <= cfg_height_i;
            end

            core_start_o <= accept;
            if (accept) core_pixel_o <= in_pixel_i;

            gray_sr[0] <= core_start_o;
            for (int i = 1; i < GRAY_LAT; i++) gray_sr[i] <= gray_sr[i-1];

            out_valid_o <= take;
            if (take) out_pixel_o <= core_pixel_i;

            if (state == S_IDLE)  in_cnt <= '0;
            else if (accept)      in_cnt <= in_cnt + CW'(1);

            if (state == S_IDLE)  out_cnt <= '0;
            else if (take)        out_cnt <= out_cnt + CW'(1);

            // Watchdog restarts on every qualified output while draining.
            if (state != S_DRAIN || take) tmo_cnt <= TW'(TIMEOUT);
            else if (tmo_cnt != '0)       tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

endmodule

// File: tb/tb_gray_sobel_frame_sequencer.sv
// Directed bench for gray_sobel_frame_sequencer: six frame scenarios with a
// simple registered core model and an event recorder on the falling edge.
module tb_gray_sobel_frame_sequencer;

    localparam int MPB = 24;
    localparam int DB  = 10;
    localparam int GL  = 1;
    localparam int TO  = 1024;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     cfg_select;
    logic [DB-1:0]  cfg_width, cfg_height;
    logic           frame_start;
    logic           in_valid;
    logic [MPB-1:0] in_pixel;
    logic           in_ready;
    logic [1:0]     core_select;
    logic           core_start;
    logic [MPB-1:0] core_pixel_to_core;
    logic [MPB-1:0] core_result;
    logic           core_px_ready;
    logic           out_valid;
    logic [MPB-1:0] out_pixel;
    logic           busy, done, err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int err_n  = 0;
    int acc_q[$], cs_q[$], ov_q[$], done_q[$];
    logic [MPB-1:0] ovpx_q[$];
    logic [MPB-1:0] mask;
    logic [MPB-1:0] core_q;
    int n;
    int err_base;

    always #5 clk = ~clk;

    gray_sobel_frame_sequencer #(
        .MAX_PIXEL_BITS(MPB), .PIXEL_WIDTH_OUT(8), .DIM_BITS(DB),
        .GRAY_LAT(GL), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .cfg_select_i(cfg_select), .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
        .frame_start_i(frame_start), .in_valid_i(in_valid), .in_pixel_i(in_pixel),
        .in_ready_o(in_ready), .core_select_o(core_select), .core_start_o(core_start),
        .core_pixel_o(core_pixel_to_core), .core_pixel_i(core_result),
        .core_px_ready_i(core_px_ready), .out_valid_o(out_valid), .out_pixel_o(out_pixel),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    // Core stand-in: result is the strobed pixel xor a mask, one cycle later.
    always @(posedge clk) core_q <= core_pixel_to_core ^ mask;
    assign core_result = core_q;

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (core_start) cs_q.push_back(cyc);
        if (out_valid) begin
            ov_q.push_back(cyc);
            ovpx_q.push_back(out_pixel);
        end
        if (done) done_q.push_back(cyc);
        if (err) err_n++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete(); cs_q.delete(); ov_q.delete(); done_q.delete(); ovpx_q.delete();
    endtask

    // Pulse frame_start in the current cycle; returns in the LOAD cycle.
    task automatic start_frame(input logic [1:0] sel, input int w, input int h);
        cfg_select  = sel;
        cfg_width   = DB'(w);
        cfg_height  = DB'(h);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic stream(input int cnt, input logic [MPB-1:0] base);
        for (int i = 0; i < cnt; i++) begin
            in_pixel = base + MPB'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!done && k < bound) begin
            tick();
            k++;
        end
        chk(tag, done, 1'b1);
        tick();
    endtask

    initial begin
        reset = 1'b1; cfg_select = 2'b00; cfg_width = '0; cfg_height = '0;
        frame_start = 1'b0; in_valid = 1'b0; in_pixel = '0; core_px_ready = 1'b0;
        mask = 24'h5A5A5A;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_drive", {core_start, core_select, core_pixel_to_core}, '0);
        chk("rst_out", {out_valid, out_pixel, done, err}, '0);
        reset = 1'b0;
        tick();

        // Frame 1: gray, 4x4, continuous valid.
        clear_q();
        start_frame(2'b00, 4, 4);
        chk("f1_load_ready", in_ready, 1'b0);
        chk("f1_load_busy", busy, 1'b1);
        tick();
        chk("f1_stream_ready", in_ready, 1'b1);
        stream(16, 24'h100000);
        chk("f1_drain_ready", in_ready, 1'b0);
        wait_done("f1_done", 20);
        chk("f1_busy_after", busy, 1'b0);
        chk("f1_accepts", acc_q.size(), 16);
        chk("f1_outputs", ov_q.size(), 16);
        if (acc_q.size() == 16 && ov_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("f1_latency", ov_q[i] - acc_q[i], 3);
                chk("f1_pixel", ovpx_q[i], (24'h100000 + 24'(i)) ^ 24'h5A5A5A);
            end
            chk("f1_done_count", done_q.size(), 1);
            if (done_q.size() == 1) chk("f1_done_timing", done_q[0], ov_q[15] + 1);
        end

        // Frame 2: bypass, 3x2, valid toggling.
        clear_q();
        mask = '0;
        start_frame(2'b11, 3, 2);
        tick();
        for (int k = 0; k < 12; k++) begin
            in_valid = (k % 2 == 0);
            in_pixel = 24'h0A0000 + 24'(k / 2);
            tick();
        end
        in_valid = 1'b0;
        wait_done("f2_done", 20);
        chk("f2_accepts", acc_q.size(), 6);
        chk("f2_strobes", cs_q.size(), 6);
        chk("f2_outputs", ov_q.size(), 6);
        if (acc_q.size() == 6 && cs_q.size() == 6 && ovpx_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("f2_strobe_timing", cs_q[i], acc_q[i] + 1);
                chk("f2_pixel", ovpx_q[i], 24'h0A0000 + 24'(i));
            end
        end
        chk("f2_done_count", done_q.size(), 1);

        // Frame 3: Sobel on gray, 5x5, ten ready pulses, ninth completes.
        clear_q();
        start_frame(2'b01, 5, 5);
        tick();
        stream(25, 24'h200000);
        for (int p = 0; p < 8; p++) begin
            core_px_ready = 1'b1; tick();
            core_px_ready = 1'b0; tick();
        end
        core_px_ready = 1'b1; tick();
        core_px_ready = 1'b1; tick();
        core_px_ready = 1'b0;
        wait_done("f3_done", 5);
        chk("f3_outputs", ov_q.size(), 9);
        chk("f3_done_count", done_q.size(), 1);

        // Frame 4: gray+Sobel with too-narrow width, then a valid 3x3.
        clear_q();
        err_base = err_n;
        start_frame(2'b10, 2, 8);
        chk("f4_load_err", err, 1'b1);
        chk("f4_load_ready", in_ready, 1'b0);
        tick();
        chk("f4_idle_busy", busy, 1'b0);
        chk("f4_idle_err", err, 1'b0);
        chk("f4_err_count", err_n - err_base, 1);
        start_frame(2'b10, 3, 3);
        chk("f4b_select", core_select, 2'b10);
        tick();
        stream(9, 24'h300000);
        core_px_ready = 1'b1; tick();
        core_px_ready = 1'b0;
        wait_done("f4b_done", 5);
        chk("f4b_outputs", ov_q.size(), 1);
        chk("f4b_accepts", acc_q.size(), 9);

        // Frame 5: Sobel 4x4, core silent -> drain watchdog.
        clear_q();
        err_base = err_n;
        start_frame(2'b01, 4, 4);
        tick();
        stream(16, 24'h400000);
        n = 0;
        while (!err && n < TO + 100) begin
            tick();
            n++;
        end
        chk("f5_timeout_cycles", n, TO);
        chk("f5_err", err, 1'b1);
        tick();
        chk("f5_busy_after", busy, 1'b0);
        chk("f5_no_done", done_q.size(), 0);
        chk("f5_err_count", err_n - err_base, 1);

        // Frame 6: gray 4x4 interrupted by reset; busy frame_start ignored.
        clear_q();
        mask = 24'h5A5A5A;
        start_frame(2'b00, 4, 4);
        tick();
        stream(5, 24'h500000);
        start_frame(2'b11, 1, 1);
        chk("f6_select_kept", core_select, 2'b00);
        chk("f6_still_stream", in_ready, 1'b1);
        stream(2, 24'h500005);
        chk("f6_pre_rst_out", out_pixel !== '0, 1'b1);
        reset = 1'b1;
        tick();
        chk("f6_rst_ready_busy", {in_ready, busy}, 2'b00);
        chk("f6_rst_core", {core_start, core_select, core_pixel_to_core}, '0);
        chk("f6_rst_out", {out_valid, out_pixel}, '0);
        chk("f6_rst_flags", {done, err}, 2'b00);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("f6_no_done", done_q.size(), 0);
        chk("f6_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_sobel_frame_sequencer.md
# gray_sobel_frame_sequencer

Frame-level controller that sits in front of the grayscale/Sobel processing top and sequences one image frame through it. Latches a mode and frame geometry, accepts a valid/ready pixel stream, drives the core's select/start/pixel inputs one strobe per accepted pixel, and qualifies the core's outputs into a valid-tagged output stream. Counts input and output pixels, signals frame completion, and flags configuration errors and drain timeouts.

## Interface
- MAX_PIXEL_BITS, 24, RGB pixel width (matches core)
- PIXEL_WIDTH_OUT, 8, gray/Sobel pixel width (matches core)
- DIM_BITS, 10, width of frame width/height fields
- GRAY_LAT, 1, core grayscale latency in cycles from start strobe to valid gray pixel (1..7)
- TIMEOUT, 1024, idle cycles in DRAIN before error
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- cfg_select_i  in  2  mode: 00 gray, 01 Sobel on gray input, 10 gray+Sobel, 11 bypass
- cfg_width_i  in  DIM_BITS  frame width W
- cfg_height_i  in  DIM_BITS  frame height H
- frame_start_i  in  1  one-cycle pulse, begins a frame
- in_valid_i  in  1  input pixel valid
- in_pixel_i  in  MAX_PIXEL_BITS  input pixel
- in_ready_o  out  1  sequencer accepts pixel this cycle
- core_select_o  out  2  to core select_i
- core_start_o  out  1  to core start_i, per-pixel strobe
- core_pixel_o  out  MAX_PIXEL_BITS  to core in_pixel_i
- core_pixel_i  in  MAX_PIXEL_BITS  from core out_pixel_o
- core_px_ready_i  in  1  from core px_ready_sobel_o
- out_valid_o  out  1  output pixel valid
- out_pixel_o  out  MAX_PIXEL_BITS  output pixel
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse, frame complete
- err_o  out  1  one-cycle pulse, config error or timeout

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: frame_start_i=1 latches cfg_select_i, cfg_width_i, cfg_height_i -> LOAD. Config inputs ignored at all other times.
- LOAD (1 cycle): validate. Sobel modes (01, 10) require W>=3 and H>=3; other modes require W>=1 and H>=1. Invalid: err_o=1, -> IDLE. Valid: -> STREAM. Expected input N_in=W*H; expected output N_out=W*H (00, 11) or (W-2)*(H-2) (01, 10). Counters are 2*DIM_BITS wide, no overflow possible.
- STREAM: in_ready_o=1. Each cycle with in_valid_i&&in_ready_o: register pixel into core_pixel_o, core_start_o=1 the next cycle; in_cnt++. On the accept with in_cnt==N_in-1 -> DRAIN. in_valid_i low inserts a gap: core_start_o=0 that cycle and core_pixel_o holds.
- DRAIN: in_ready_o=0. Wait until out_cnt==N_out -> DONE. TIMEOUT consecutive cycles with no output qualified -> err_o=1, -> IDLE.
- DONE (1 cycle): done_o=1, -> IDLE.
- Output qualification, active in STREAM and DRAIN: mode 00: core_start_o delayed GRAY_LAT cycles via shift register. Mode 11: core_start_o delayed 1 cycle. Modes 01/10: core_px_ready_i. On qualification, register out_valid_o=1 and out_pixel_o=core_pixel_i; out_cnt++.
- Outputs beyond N_out are dropped and do not assert out_valid_o.
- core_select_o = latched select in LOAD/STREAM/DRAIN/DONE, 00 in IDLE.
- busy_o=1 in every state except IDLE.
- frame_start_i while busy: ignored.

## Timing
- Reset, and any cycle with reset_i=1 including mid-frame, gives: state IDLE, counters 0, shift register cleared, in_ready_o=0, core_start_o=0, core_select_o=00, core_pixel_o=0, out_valid_o=0, out_pixel_o=0, busy_o=0, done_o=0, err_o=0. No done_o after a mid-frame reset.
- frame_start_i at cycle t: LOAD at t+1, first in_ready_o at t+2.
- Pixel accepted at cycle a: core_start_o/core_pixel_o at a+1.
- Output valid timing: mode 00 at a+1+GRAY_LAT+1. Mode 11 at a+3. Sobel modes one cycle after core_px_ready_i.
- done_o asserts the cycle after the final out_valid_o. Back-to-back frames allowed: frame_start_i is accepted on the cycle after done_o.
- Throughput: one pixel per cycle in STREAM with in_valid_i held high.

## Test plan
- Mode 00, W=4, H=4, continuous valid, GRAY_LAT=1 -> 16 accepts, 16 out_valid_o each 3 cycles after accept, done_o once, busy_o low after.
- Mode 11, W=3, H=2, in_valid_i toggling 1/0 -> 6 core_start_o strobes with gaps mirrored; out_pixel_o equals input pixels in order; done_o.
- Mode 01, W=5, H=5, core model asserting core_px_ready_i 9 times -> out_cnt=9, 10th core_px_ready_i ignored, done_o.
- Mode 10, W=2, H=8 -> err_o pulse in LOAD, no in_ready_o, back to IDLE; a following valid 3x3 frame completes.
- Mode 01, W=4, H=4, core never asserts ready -> err_o exactly TIMEOUT cycles after entering DRAIN, state IDLE.
- reset_i pulse mid-STREAM of a 4x4 mode 00 frame -> all outputs at reset values next cycle, no done_o; frame_start_i during busy ignored.
